ddram_arb: RTL and testbench

- Two-client arbiter that shares the single high-latency DDR3 port (DDRAM_*) inside emu.
- Client 0 is the loader/writer; client 1 is the video/framebuffer reader.
- Sequences each command onto DDRAM: holds it through DDRAM_BUSY, counts read beats, routes data back to the owner, then re-arbitrates.
- DDRAM_CLK is tied to clk_sys at emu level, outside this block.

---
 rtl/ddram_arb.sv | 156 +++++++++++++++
 tb/tb_ddram_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_arb.sv
// Two-client arbiter for the shared DDR3 port: client 0 is the loader/writer, client 1 the video reader.
// One command in flight at a time: issue, hold through BUSY, collect read beats, one dead cycle, re-arbitrate.
module ddram_arb #(
    parameter int PRIO = 0
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic        c0_req,
    input  logic        c0_we,
    input  logic [28:0] c0_addr,
    input  logic [7:0]  c0_burst,
    input  logic [63:0] c0_din,
    input  logic [7:0]  c0_be,
    output logic        c0_ack,
    output logic [63:0] c0_dout,
    output logic        c0_dvalid,

    input  logic        c1_req,
    input  logic        c1_we,
    input  logic [28:0] c1_addr,
    input  logic [7:0]  c1_burst,
    input  logic [63:0] c1_din,
    input  logic [7:0]  c1_be,
    output logic        c1_ack,
    output logic [63:0] c1_dout,
    output logic        c1_dvalid,

    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA, GAP} state_t;

    state_t      state, state_nxt;
    logic        rr_last;
    logic        owner;
    logic        owner_we;
    logic [7:0]  beats;

    logic        grant_any;
    logic        grant_sel;
    logic        sel_we;
    logic [28:0] sel_addr;
    logic [7:0]  sel_burst;
    logic [63:0] sel_din;
    logic [7:0]  sel_be;

    function automatic logic [7:0] norm_burst(input logic we, input logic [7:0] burst);
        if (we || burst == 8'd0) return 8'd1;
        return burst;
    endfunction

    always_comb begin
        grant_any = c0_req | c1_req;
        grant_sel = c1_req & (~c0_req | ((PRIO == 0) & ~rr_last));
        sel_we    = grant_sel ? c1_we    : c0_we;
        sel_addr  = grant_sel ? c1_addr  : c0_addr;
        sel_burst = grant_sel ? c1_burst : c0_burst;
        sel_din   = grant_sel ? c1_din   : c0_din;
        sel_be    = grant_sel ? c1_be    : c0_be;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (grant_any) state_nxt = ISSUE;
            ISSUE: if (!DDRAM_BUSY) state_nxt = owner_we ? GAP : RDATA;
            RDATA: if (DDRAM_DOUT_READY && beats == 8'd1) state_nxt = GAP;
            GAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rr_last        <= 1'b1;
            owner          <= 1'b0;
            owner_we       <= 1'b0;
            beats          <= 8'd0;
            c0_ack         <= 1'b0;
            c0_dout        <= 64'd0;
            c0_dvalid      <= 1'b0;
            c1_ack         <= 1'b0;
            c1_dout        <= 64'd0;
            c1_dvalid      <= 1'b0;
            DDRAM_BURSTCNT <= 8'd0;
            DDRAM_ADDR     <= 29'd0;
            DDRAM_RD       <= 1'b0;
            DDRAM_DIN      <= 64'd0;
            DDRAM_BE       <= 8'd0;
            DDRAM_WE       <= 1'b0;
        end else begin
            c0_ack    <= 1'b0;
            c1_ack    <= 1'b0;
            c0_dvalid <= 1'b0;
            c1_dvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner          <= grant_sel;
                        owner_we       <= sel_we;
                        rr_last        <= grant_sel;
                        DDRAM_ADDR     <= sel_addr;
                        DDRAM_DIN      <= sel_din;
                        DDRAM_BE       <= sel_be;
                        DDRAM_BURSTCNT <= norm_burst(sel_we, sel_burst);
                        DDRAM_RD       <= ~sel_we;
                        DDRAM_WE       <= sel_we;
                    end
                end
                ISSUE: begin
                    // Command and fields stay frozen until the controller drops BUSY.
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        DDRAM_WE <= 1'b0;
                        if (owner_we) begin
                            c0_ack <= ~owner;
                            c1_ack <= owner;
                        end else begin
                            beats <= DDRAM_BURSTCNT;
                        end
                    end
                end
                RDATA: begin
                    if (DDRAM_DOUT_READY) begin
                        beats <= beats - 8'd1;
                        if (owner) begin
                            c1_dout   <= DDRAM_DOUT;
                            c1_dvalid <= 1'b1;
                            c1_ack    <= (beats == 8'd1);
                        end else begin
                            c0_dout   <= DDRAM_DOUT;
                            c0_dvalid <= 1'b1;
                            c0_ack    <= (beats == 8'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_arb.sv
// Directed bench for ddram_arb: a round-robin instance plus a fixed-priority instance on shared inputs.
module tb_ddram_arb;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [28:0] c0_addr, c1_addr;
    logic [7:0]  c0_burst, c1_burst, c0_be, c1_be;
    logic [63:0] c0_din, c1_din;
    logic        DDRAM_BUSY, DDRAM_DOUT_READY;
    logic [63:0] DDRAM_DOUT;

    logic        c0_ack, c0_dvalid, c1_ack, c1_dvalid;
    logic [63:0] c0_dout, c1_dout;
    logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
    logic [28:0] DDRAM_ADDR;
    logic        DDRAM_RD, DDRAM_WE;
    logic [63:0] DDRAM_DIN;

    logic        b_c0_ack, b_c0_dvalid, b_c1_ack, b_c1_dvalid;
    logic [63:0] b_c0_dout, b_c1_dout;
    logic [7:0]  b_burstcnt, b_be;
    logic [28:0] b_addr;
    logic        b_rd, b_we;
    logic [63:0] b_din;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    ddram_arb #(.PRIO(0)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_burst(c0_burst),
        .c0_din(c0_din), .c0_be(c0_be), .c0_ack(c0_ack), .c0_dout(c0_dout), .c0_dvalid(c0_dvalid),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_burst(c1_burst),
        .c1_din(c1_din), .c1_be(c1_be), .c1_ack(c1_ack), .c1_dout(c1_dout), .c1_dvalid(c1_dvalid),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
        .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
    );

    ddram_arb #(.PRIO(1)) dut_prio (
        .clk_sys(clk_sys), .reset(reset),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_burst(c0_burst),
        .c0_din(c0_din), .c0_be(c0_be), .c0_ack(b_c0_ack), .c0_dout(b_c0_dout), .c0_dvalid(b_c0_dvalid),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_burst(c1_burst),
        .c1_din(c1_din), .c1_be(c1_be), .c1_ack(b_c1_ack), .c1_dout(b_c1_dout), .c1_dvalid(b_c1_dvalid),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(b_burstcnt), .DDRAM_ADDR(b_addr),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(b_rd),
        .DDRAM_DIN(b_din), .DDRAM_BE(b_be), .DDRAM_WE(b_we)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        c0_req = 0; c0_we = 0; c0_addr = '0; c0_burst = '0; c0_din = '0; c0_be = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_burst = '0; c1_din = '0; c1_be = '0;
        DDRAM_BUSY = 0; DDRAM_DOUT_READY = 0; DDRAM_DOUT = '0;
        tick(); tick();
        chk("rst_rd", DDRAM_RD, 0);
        chk("rst_we", DDRAM_WE, 0);
        chk("rst_addr", DDRAM_ADDR, 0);
        chk("rst_burstcnt", DDRAM_BURSTCNT, 0);
        chk("rst_acks", {c0_ack, c1_ack, c0_dvalid, c1_dvalid}, 0);
        chk("rst_dout", c1_dout | c0_dout, 0);
        reset = 1'b0;

        // 1: single c0 write, no stall
        c0_req = 1; c0_we = 1; c0_addr = 29'h100; c0_din = 64'hDEADBEEF_01234567; c0_be = 8'hFF; c0_burst = 8'd9;
        tick();
        chk("t1_we", DDRAM_WE, 1);
        chk("t1_rd", DDRAM_RD, 0);
        chk("t1_addr", DDRAM_ADDR, 64'h100);
        chk("t1_din", DDRAM_DIN, 64'hDEADBEEF_01234567);
        chk("t1_be", DDRAM_BE, 8'hFF);
        chk("t1_burstcnt", DDRAM_BURSTCNT, 1);
        chk("t1_ack_early", c0_ack, 0);
        tick();
        chk("t1_we_drop", DDRAM_WE, 0);
        chk("t1_ack", c0_ack, 1);
        chk("t1_c1_ack", c1_ack, 0);
        c0_req = 0;
        tick();
        chk("t1_ack_pulse", c0_ack, 0);
        tick();

        // 2: c1 burst read of 4 behind a 3-cycle stall, beats with gaps
        c1_req = 1; c1_we = 0; c1_addr = 29'h2000; c1_burst = 8'd4;
        DDRAM_BUSY = 1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_rd_hold%0d", i), {DDRAM_RD, DDRAM_WE}, 2'b10);
            chk($sformatf("t2_addr%0d", i), DDRAM_ADDR, 64'h2000);
            chk($sformatf("t2_burstcnt%0d", i), DDRAM_BURSTCNT, 4);
            if (i == 3) DDRAM_BUSY = 0;
            tick();
        end
        chk("t2_rd_drop", DDRAM_RD, 0);
        for (int v = 1; v <= 4; v++) begin
            tick();
            chk($sformatf("t2_gap_dvalid%0d", v), c1_dvalid, 0);
            DDRAM_DOUT_READY = 1; DDRAM_DOUT = 64'(v);
            tick();
            DDRAM_DOUT_READY = 0;
            chk($sformatf("t2_dvalid%0d", v), c1_dvalid, 1);
            chk($sformatf("t2_dout%0d", v), c1_dout, 64'(v));
            chk($sformatf("t2_ack%0d", v), c1_ack, (v == 4) ? 1 : 0);
            chk($sformatf("t2_c0_quiet%0d", v), {c0_ack, c0_dvalid, c0_dout}, 0);
        end
        c1_req = 0;
        tick();
        chk("t2_ack_pulse", {c1_ack, c1_dvalid}, 0);
        tick();

        // 4: burst 0 reads one beat; DOUT_READY in IDLE is ignored
        c1_req = 1; c1_we = 0; c1_addr = 29'h77; c1_burst = 8'd0;
        tick();
        chk("t4_rd", DDRAM_RD, 1);
        chk("t4_burstcnt", DDRAM_BURSTCNT, 1);
        tick();
        DDRAM_DOUT_READY = 1; DDRAM_DOUT = 64'hABCD;
        tick();
        DDRAM_DOUT_READY = 0;
        chk("t4_dvalid", c1_dvalid, 1);
        chk("t4_dout", c1_dout, 64'hABCD);
        chk("t4_ack", c1_ack, 1);
        c1_req = 0;
        tick();
        DDRAM_DOUT_READY = 1; DDRAM_DOUT = 64'h5555;
        tick();
        DDRAM_DOUT_READY = 0;
        chk("t4_spurious_dvalid", {c0_dvalid, c1_dvalid}, 0);
        chk("t4_spurious_dout", c1_dout, 64'hABCD);
        tick();

        // 5: reset after two of eight beats
        c1_req = 1; c1_we = 0; c1_addr = 29'h3000; c1_burst = 8'd8;
        tick();
        tick();
        DDRAM_DOUT_READY = 1; DDRAM_DOUT = 64'h11;
        tick();
        chk("t5_beat1", c1_dout, 64'h11);
        DDRAM_DOUT = 64'h22;
        tick();
        chk("t5_beat2", c1_dout, 64'h22);
        reset = 1; DDRAM_DOUT = 64'h33;
        tick();
        chk("t5_rst_dout", c1_dout, 0);
        chk("t5_rst_flags", {c1_dvalid, c1_ack, DDRAM_RD, DDRAM_WE}, 0);
        chk("t5_rst_fields", {DDRAM_ADDR, DDRAM_BURSTCNT}, 0);
        reset = 0; c1_req = 0;
        for (int i = 0; i < 5; i++) begin
            DDRAM_DOUT = 64'(8'h44 + 8'(i * 17));
            tick();
            chk($sformatf("t5_ignored%0d", i), {c0_dvalid, c1_dvalid, c1_ack}, 0);
        end
        DDRAM_DOUT_READY = 0;
        c0_req = 1; c0_we = 1; c0_addr = 29'h55; c0_din = 64'h1; c0_be = 8'h01;
        tick();
        chk("t5_we", DDRAM_WE, 1);
        chk("t5_addr", DDRAM_ADDR, 64'h55);
        tick();
        chk("t5_ack", c0_ack, 1);
        c0_req = 0;
        tick(); tick();

        // 6: long write stall with a c1 request arriving mid-stall
        c0_req = 1; c0_we = 1; c0_addr = 29'h400; c0_din = 64'hCAFE_F00D_0000_1111; c0_be = 8'h0F;
        DDRAM_BUSY = 1;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t6_hold%0d", i),
                {DDRAM_WE, DDRAM_RD, 27'd0, DDRAM_ADDR, DDRAM_BE} == {1'b1, 1'b0, 27'd0, 29'h400, 8'h0F}, 1);
            chk($sformatf("t6_din%0d", i), DDRAM_DIN, 64'hCAFE_F00D_0000_1111);
            chk($sformatf("t6_noack%0d", i), c0_ack, 0);
            if (i == 4) begin
                c1_req = 1; c1_we = 0; c1_addr = 29'h500; c1_burst = 8'd2;
            end
            if (i == 9) DDRAM_BUSY = 0;
            tick();
        end
        chk("t6_ack", c0_ack, 1);
        chk("t6_c1_not_yet", {DDRAM_RD, c1_ack}, 0);
        c0_req = 0;
        tick();
        chk("t6_gap", {DDRAM_RD, DDRAM_WE, c0_ack}, 0);
        tick();
        chk("t6_c1_rd", DDRAM_RD, 1);
        chk("t6_c1_addr", DDRAM_ADDR, 64'h500);
        chk("t6_c1_burstcnt", DDRAM_BURSTCNT, 2);
        tick();
        DDRAM_DOUT_READY = 1; DDRAM_DOUT = 64'hA1;
        tick();
        chk("t6_beat1", {c1_dvalid, c1_ack}, 2'b10);
        DDRAM_DOUT = 64'hA2;
        tick();
        DDRAM_DOUT_READY = 0;
        chk("t6_beat2", {c1_dvalid, c1_ack}, 2'b11);
        chk("t6_dout2", c1_dout, 64'hA2);
        c1_req = 0;
        tick();

        // 3: both clients requesting continuously, from a clean reset
        reset = 1;
        tick();
        reset = 0;
        c0_req = 1; c0_we = 1; c0_addr = 29'h10; c0_din = 64'h10; c0_be = 8'hFF;
        c1_req = 1; c1_we = 1; c1_addr = 29'h20; c1_din = 64'h20; c1_be = 8'hFF;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk($sformatf("t3_rr_we%0d", t), DDRAM_WE, 1);
            chk($sformatf("t3_rr_addr%0d", t), DDRAM_ADDR, (t % 2 == 0) ? 64'h10 : 64'h20);
            chk($sformatf("t3_prio_addr%0d", t), b_addr, 64'h10);
            tick();
            chk($sformatf("t3_rr_ack%0d", t), {c0_ack, c1_ack}, (t % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("t3_prio_ack%0d", t), {b_c0_ack, b_c1_ack}, 2'b10);
            tick();
        end
        c0_req = 0; c1_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
